// File: rtl/zone_if.sv
// zone_if: request/permit inputs and valve/pump drive outputs of the zone scheduler.
interface zone_if #(parameter int N_ZONES = 4, parameter int CNT_W = 8);
  localparam int IW = $clog2(N_ZONES);
  logic [N_ZONES-1:0] req;
  logic               enable;
  logic [CNT_W-1:0]   max_on;
  logic [N_ZONES-1:0] valve;
  logic               pump;
  logic               busy;
  logic [IW-1:0]      active_zone;
  logic               timeout;
  modport master(output req, enable, max_on, input valve, pump, busy, active_zone, timeout);
  modport slave(input req, enable, max_on, output valve, pump, busy, active_zone, timeout);
endinterface

// File: rtl/zone_scheduler.sv
// zone_scheduler: round-robin grant of one shared pump to N_ZONES valves with settle and run-time limit.
module zone_scheduler #(
  parameter int N_ZONES = 4,
  parameter int CNT_W   = 8,
  parameter int SETTLE  = 2
) (
  input logic   clk,
  input logic   reset,
  zone_if.slave zif
);
  localparam int IW = $clog2(N_ZONES);
  localparam int SW = $clog2(SETTLE + 1);
  typedef enum logic [1:0] {IDLE, OPEN, WATER, CLOSE} state_t;
  state_t             state_q, state_d;
  logic [IW-1:0]      last_q, last_d, act_q, act_d, win, cand;
  logic [N_ZONES-1:0] valve_q, valve_d;
  logic               pump_q, pump_d, to_q, to_d, busy_q, busy_d, hold;
  logic [SW-1:0]      set_q, set_d;
  logic [CNT_W-1:0]   run_q, run_d, max_q, max_d;
  always_comb begin
    win = last_q;
    cand = '0;
    // Descending scan so the nearest zone after last wins.
    for (int i = N_ZONES; i >= 1; i--) begin
      cand = IW'((int'(last_q) + i) % N_ZONES);
      if (zif.req[cand]) win = cand;
    end
    hold = zif.req[act_q] && zif.enable;
    state_d = state_q;
    last_d = last_q;
    act_d = act_q;
    valve_d = valve_q;
    pump_d = 1'b0;
    to_d = 1'b0;
    set_d = set_q;
    run_d = run_q;
    max_d = max_q;
    case (state_q)
      IDLE:
        if (zif.enable && zif.max_on != '0 && zif.req != '0) begin
          state_d = OPEN;
          last_d = win;
          act_d = win;
          valve_d = N_ZONES'(1) << win;
          max_d = zif.max_on;
          set_d = SW'(SETTLE - 1);
        end
      OPEN:
        if (!hold) begin
          state_d = IDLE;
          valve_d = '0;
          act_d = '0;
          set_d = '0;
        end else if (set_q == '0) begin
          state_d = WATER;
          pump_d = 1'b1;
          run_d = CNT_W'(1);
        end else set_d = set_q - 1'b1;
      WATER:
        if (run_q == max_q || !hold) begin
          state_d = CLOSE;
          to_d = run_q == max_q;
          set_d = SW'(SETTLE - 1);
          run_d = '0;
        end else begin
          pump_d = 1'b1;
          run_d = run_q + 1'b1;
        end
      default:
        if (set_q == '0) begin
          state_d = IDLE;
          valve_d = '0;
          act_d = '0;
        end else set_d = set_q - 1'b1;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      last_q <= IW'(N_ZONES - 1);
      act_q <= '0;
      valve_q <= '0;
      pump_q <= 1'b0;
      to_q <= 1'b0;
      busy_q <= 1'b0;
      set_q <= '0;
      run_q <= '0;
      max_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      act_q <= act_d;
      valve_q <= valve_d;
      pump_q <= pump_d;
      to_q <= to_d;
      busy_q <= busy_d;
      set_q <= set_d;
      run_q <= run_d;
      max_q <= max_d;
    end
  assign zif.valve = valve_q;
  assign zif.pump = pump_q;
  assign zif.busy = busy_q;
  assign zif.active_zone = act_q;
  assign zif.timeout = to_q;
endmodule

// File: tb/tb_zone_scheduler.sv
// tb_zone_scheduler: directed checks of grant order, timing, drops, blocking and async reset.
module tb_zone_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int pc, tc;
  zone_if #(.N_ZONES(4), .CNT_W(8)) zif ();
  zone_scheduler #(.N_ZONES(4), .CNT_W(8), .SETTLE(2)) dut (.clk(clk), .reset(reset), .zif(zif));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    chk("onehot_valve", 32'($onehot0(zif.valve)), 1);
    chk("pump_wo_valve", 32'(zif.pump && zif.valve == '0), 0);
  end
  initial begin
    zif.req = '0;
    zif.enable = 1'b1;
    zif.max_on = 8'd5;
    repeat (2) @(negedge clk);
    chk("rst_valve", zif.valve, 0);
    chk("rst_pump", zif.pump, 0);
    chk("rst_busy", zif.busy, 0);
    chk("rst_az", zif.active_zone, 0);
    chk("rst_to", zif.timeout, 0);
    reset = 1'b0;
    // single zone 1 held: grant at E0, re-grant at E0+10
    zif.req = 4'b0010;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      chk("z1_valve", zif.valve, (k <= 8 || k == 10) ? 4'b0010 : 4'b0000);
      chk("z1_pump", zif.pump, (k >= 2 && k <= 6) ? 1 : 0);
      chk("z1_to", zif.timeout, k == 7 ? 1 : 0);
      chk("z1_busy", zif.busy, (k <= 8 || k == 10) ? 1 : 0);
      chk("z1_az", zif.active_zone, (k <= 8 || k == 10) ? 1 : 0);
    end
    zif.req = '0;
    @(negedge clk);
    chk("z1_drop_busy", zif.busy, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    // all zones held: rotation 0,1,2,3,0
    zif.req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("rr_az", zif.active_zone, j % 4);
      chk("rr_busy", zif.busy, 1);
      pc = 0;
      for (int k = 1; k <= 7; k++) begin
        @(negedge clk);
        pc += int'(zif.pump);
      end
      chk("rr_pump_cycles", pc, 5);
      chk("rr_to", zif.timeout, 1);
      repeat (2) @(negedge clk);
      chk("rr_idle", zif.busy, 0);
    end
    zif.req = '0;
    // zone 2, dropped after 2 pump cycles
    zif.req = 4'b0100;
    pc = 0;
    tc = 0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      pc += int'(zif.pump);
      tc += int'(zif.timeout);
      chk("drop_valve", zif.valve, k <= 5 ? 4'b0100 : 4'b0000);
      if (k == 3) zif.req = '0;
    end
    chk("drop_pump_cycles", pc, 2);
    chk("drop_no_to", tc, 0);
    chk("drop_idle", zif.busy, 0);
    // blocked by max_on=0, then by enable=0
    zif.req = 4'b1111;
    zif.max_on = 8'd0;
    tc = 0;
    repeat (20) begin
      @(negedge clk);
      tc += int'(zif.busy);
    end
    chk("blk_max0", tc, 0);
    zif.max_on = 8'd5;
    zif.enable = 1'b0;
    tc = 0;
    repeat (20) begin
      @(negedge clk);
      tc += int'(zif.busy);
    end
    chk("blk_en0", tc, 0);
    // enable dropped in 3rd WATER cycle; pointer at 2 so zone 3 wins
    zif.enable = 1'b1;
    pc = 0;
    tc = 0;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      pc += int'(zif.pump);
      tc += int'(zif.timeout);
      if (k == 0) chk("en_az", zif.active_zone, 3);
      if (k == 4) zif.enable = 1'b0;
      if (k == 6) chk("en_close_valve", zif.valve, 4'b1000);
    end
    chk("en_pump_cycles", pc, 3);
    chk("en_no_to", tc, 0);
    chk("en_idle", zif.busy, 0);
    zif.req = '0;
    zif.enable = 1'b1;
    // zone 0 dropped in first OPEN cycle, then 1001 goes to zone 3
    zif.req = 4'b0001;
    @(negedge clk);
    chk("open_az", zif.active_zone, 0);
    chk("open_valve", zif.valve, 4'b0001);
    zif.req = '0;
    @(negedge clk);
    chk("open_abort_busy", zif.busy, 0);
    chk("open_abort_valve", zif.valve, 0);
    chk("open_abort_pump", zif.pump, 0);
    zif.req = 4'b1001;
    @(negedge clk);
    chk("next_az", zif.active_zone, 3);
    chk("next_valve", zif.valve, 4'b1000);
    repeat (2) @(negedge clk);
    chk("mid_water_pump", zif.pump, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_pump", zif.pump, 0);
    chk("async_valve", zif.valve, 0);
    chk("async_busy", zif.busy, 0);
    chk("async_az", zif.active_zone, 0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
